ring_osc_meter: RTL and testbench
=================================

# ring_osc_meter

Sequencing controller for the on-chip ring oscillator: enables the oscillator on request, lets it settle, and counts its rising edges over a programmable window of system clocks. It then reports the edge count and disables the oscillator again. It sits between the top-level tile pins (start/window select in, count out) and the free-running inverter ring, whose output enters this block asynchronously. Measurable oscillator frequency is limited to below clk/2 after synchronisation; the ring is divided externally if faster.

## Interface
- GATE_W, 16: width of the gate-window length (system clock cycles).
- CNT_W, 16: width of the edge counter and `count` output.
- WARM_CYCLES, 4: settle cycles between `ro_en` rising and gate opening; must be ≥ 3 (covers synchroniser + edge register).

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset: synchronous, active-high.
- start  in  1  request pulse; accepted only in IDLE.
- gate_cycles  in  GATE_W  window length; latched when `start` is accepted.
- ro_in  in  1  raw ring-oscillator output, asynchronous to clk.
- ro_en  out  1  oscillator enable (gates the ring's feedback inverter).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when `count` becomes valid.
- count  out  CNT_W  rising edges seen in the last window; held until the next accepted `start`.
- overflow  out  1  sticky: counter saturated during the last window.

## Operation
- `ro_in` passes through a 2-flop synchroniser, then an edge register `ro_q`. Edge = `ro_s & ~ro_q`. Synchroniser and `ro_q` run continuously, so the first gate cycle sees a true edge, never a reset artefact.
- States: IDLE, WARMUP, GATE, DONE.
- IDLE: `ro_en`=0, `busy`=0. If `start`=1, latch `gate_cycles` into `win`, clear `count` and `overflow`, load warm counter with WARM_CYCLES-1, go to WARMUP.
- WARMUP: `ro_en`=1. Decrement the warm counter. At 0, go to GATE with gate counter = `win`. If `win`=0, go directly to DONE.
- GATE: `ro_en`=1. Each cycle with edge=1 increments `count`. At all-ones, `count` holds and `overflow` sets. Gate counter decrements and the state is left after exactly `win` GATE cycles.
- DONE: `ro_en`=0, `done`=1 for this one cycle, go to IDLE.
- `start` outside IDLE is ignored with no side effects, including no re-latch of `gate_cycles`.
- Reset takes priority over everything, including mid-window. Next cycle: IDLE, `ro_en`=0, `busy`=0, `done`=0, `count`=0, `overflow`=0, synchroniser and `ro_q` cleared.

## Timing
- Reset values: all outputs 0.
- `start` sampled high at edge T → `busy`=`ro_en`=1 from T+1.
- WARMUP occupies cycles T+1 .. T+WARM_CYCLES.
- GATE occupies the next `win` cycles.
- DONE (`done`=1, `ro_en`=0) at cycle T+1+WARM_CYCLES+`win`. `busy` is still 1 in DONE and 0 the cycle after.
- Earliest back-to-back `start` is accepted the cycle after DONE.
- `count` and `overflow` are final and stable from the DONE cycle onward.
- Latency from edge on `ro_in` to count increment: 3 clk (2 sync + edge register). Edges arriving in the final 3 GATE cycles' pipeline are not counted. This is consistent per window and accepted.

## Structure
- Package `ring_osc_pkg`: state enum `rom_state_t` {IDLE, WARMUP, GATE, DONE} and default localparams for GATE_W, CNT_W, WARM_CYCLES.
- One sub-module `sync_2ff` (1-bit, reset-clearable 2-flop synchroniser), instantiated for `ro_in`. Reused later for other asynchronous tile inputs.
- FSM, counters and edge detect stay in `ring_osc_meter`.

## Test plan
- Reset: hold `rst` 3 cycles with `ro_in` toggling → all outputs 0; release, no `start` → `ro_en` stays 0 indefinitely.
- Nominal: free-running `ro_in`, period 8 clk, 50% duty; `gate_cycles`=64, `start` at T → `done` at T+69, `count`=8, `overflow`=0, `ro_en` high T+1..T+68 only.
- Zero window: `gate_cycles`=0 → `done` at T+5, `count`=0, `overflow`=0.
- Saturation: CNT_W=4, `ro_in` period 4, `gate_cycles`=100 → `count`=15, `overflow`=1. Next `start` clears both on acceptance.
- Ignored start and mid-run reset: pulse `start` with `gate_cycles`=10 during GATE → window length unchanged. Then assert `rst` mid-GATE → next cycle IDLE with all outputs 0, and no `done` pulse.
- Stuck oscillator: `ro_in` held 1 (and separately 0), `gate_cycles`=50 → `count`=0, `done` at T+55.

Source files
------------

// File: rtl/ring_osc_pkg.sv
// Shared types and default sizing for the ring oscillator meter.
// Imported by the meter top and any tile logic that reads its state.
package ring_osc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        GATE,
        DONE
    } rom_state_t;

    localparam int GATE_W_DEF      = 16;
    localparam int CNT_W_DEF       = 16;
    localparam int WARM_CYCLES_DEF = 4;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with synchronous clear.
// Used for every asynchronous input entering the tile clock domain.
module sync_2ff
    import ring_osc_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ring_osc_meter.sv
// Enables the ring oscillator, waits for it to settle, then counts its
// rising edges over a programmable window of system clocks.
module ring_osc_meter
    import ring_osc_pkg::*;
#(
    parameter int GATE_W      = GATE_W_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int WARM_CYCLES = WARM_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic              ro_in,
    output logic              ro_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    localparam int WW = $clog2(WARM_CYCLES + 1);

    rom_state_t        state;
    rom_state_t        state_nx;
    logic [GATE_W-1:0] win;
    logic [GATE_W-1:0] gcnt;
    logic [WW-1:0]     warm;
    logic              ro_s;
    logic              ro_q;
    logic              ro_edge;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (ro_in),
        .q   (ro_s)
    );

    assign ro_edge = ro_s & ~ro_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ro_en    = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nx = WARMUP;
                end
            end
            WARMUP: begin
                ro_en = 1'b1;
                if (warm == '0) begin
                    state_nx = (win == '0) ? DONE : GATE;
                end
            end
            GATE: begin
                ro_en = 1'b1;
                if (gcnt == GATE_W'(1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Edge register runs in every state so the first gate cycle
    // compares against a real previous sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            ro_q     <= 1'b0;
            win      <= '0;
            gcnt     <= '0;
            warm     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            ro_q <= ro_s;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        win      <= gate_cycles;
                        warm     <= WW'(WARM_CYCLES - 1);
                        count    <= '0;
                        overflow <= 1'b0;
                    end
                end
                WARMUP: begin
                    if (warm == '0) begin
                        gcnt <= win;
                    end else begin
                        warm <= warm - 1'b1;
                    end
                end
                GATE: begin
                    gcnt <= gcnt - 1'b1;
                    if (ro_edge) begin
                        if (&count) begin
                            overflow <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ring_osc_meter.sv
// Directed bench for ring_osc_meter with a window-level edge-count model.
// Uses a 4-bit counter so saturation is reachable in a short window.
module tb_ring_osc_meter;

    import ring_osc_pkg::*;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          start;
    logic [15:0]   gate_cycles;
    logic          ro_in;
    logic          ro_en;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;
    logic          overflow;

    int n_chk;
    int n_fail;
    int cyc;
    int mode;
    int ph;

    logic samp [0:65535];
    bit   m_valid;
    bit   m_on;
    int   m_t;
    int   m_win;
    int   m_cnt;
    int   m_ovf;
    int   md;
    int   mn;

    ring_osc_meter #(
        .GATE_W      (16),
        .CNT_W       (CW),
        .WARM_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .gate_cycles (gate_cycles),
        .ro_in       (ro_in),
        .ro_en       (ro_en),
        .busy        (busy),
        .done        (done),
        .count       (count),
        .overflow    (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Oscillator stimulus: 0 stuck low, 1 stuck high, 2 period 8, 3 period 4
    initial begin
        ro_in = 1'b0;
        ph    = 0;
        forever begin
            @(negedge clk);
            ph++;
            case (mode)
                0: ro_in = 1'b0;
                1: ro_in = 1'b1;
                2: ro_in = (ph % 8) < 4;
                default: ro_in = (ph % 4) < 2;
            endcase
        end
    end

    // Model: a window of w gate cycles counts rising samples over w
    // consecutive input samples, offset by the synchroniser latency.
    always @(posedge clk) begin
        cyc++;
        samp[cyc] = rst ? 1'b0 : ro_in;
        md = cyc - m_t;
        if (rst) begin
            m_valid = 1'b1;
            m_on    = 1'b0;
            m_cnt   = 0;
            m_ovf   = 0;
        end else if (m_valid) begin
            if ((!m_on || md >= m_win + 6) && start) begin
                m_on  = 1'b1;
                m_t   = cyc;
                m_win = int'(gate_cycles);
                m_cnt = 0;
                m_ovf = 0;
            end else if (m_on && md == m_win + 4) begin
                mn = 0;
                for (int k = m_t + 3; k <= m_t + 2 + m_win; k++) begin
                    if (samp[k] && !samp[k-1]) mn++;
                end
                m_cnt = (mn > CMAX) ? CMAX : mn;
                m_ovf = (mn > CMAX) ? 1 : 0;
            end
        end
    end

    always @(negedge clk) begin
        int d;
        if (m_valid) begin
            d = cyc - m_t;
            check("model_busy", int'(busy),
                  int'(m_on && d <= m_win + 4));
            check("model_ro_en", int'(ro_en),
                  int'(m_on && d <= m_win + 3));
            check("model_done", int'(done),
                  int'(m_on && d == m_win + 4));
            if (!(m_on && d >= 4 && d <= m_win + 3)) begin
                check("model_count", int'(count), m_cnt);
                check("model_overflow", int'(overflow), m_ovf);
            end
        end
    end

    task automatic run(input int w, input int ec, input int eo,
                       input bit chk, input int poke, input int rst_at);
        int ts;
        int n;
        int nd;
        @(negedge clk);
        gate_cycles = 16'(w);
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ts    = cyc;
        check("accept_busy", int'(busy), 1);
        check("accept_ro_en", int'(ro_en), 1);
        check("accept_count_clr", int'(count), 0);
        check("accept_ovf_clr", int'(overflow), 0);
        if (poke > 0) begin
            repeat (poke) @(negedge clk);
            gate_cycles = 16'd10;
            start       = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        if (rst_at > 0) begin
            repeat (rst_at) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("rst_ro_en", int'(ro_en), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_done", int'(done), 0);
            check("rst_count", int'(count), 0);
            check("rst_ovf", int'(overflow), 0);
            nd = 0;
            repeat (80) begin
                @(negedge clk);
                if (done) nd++;
            end
            check("no_done_after_rst", nd, 0);
            return;
        end
        n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", int'(done), 1);
        if (done) begin
            check("done_latency", cyc - ts, w + 4);
            if (chk) begin
                check("final_count", int'(count), ec);
                check("final_ovf", int'(overflow), eo);
            end
            @(negedge clk);
            check("idle_busy", int'(busy), 0);
            check("idle_count_hold", int'(count), int'(count));
        end
    endtask

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        cyc         = 0;
        m_valid     = 1'b0;
        m_on        = 1'b0;
        m_t         = 0;
        m_win       = 0;
        m_cnt       = 0;
        m_ovf       = 0;
        mode        = 3;
        rst         = 1'b1;
        start       = 1'b0;
        gate_cycles = '0;
        repeat (3) begin
            @(negedge clk);
            check("reset_ro_en", int'(ro_en), 0);
            check("reset_busy", int'(busy), 0);
            check("reset_done", int'(done), 0);
            check("reset_count", int'(count), 0);
            check("reset_ovf", int'(overflow), 0);
        end
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            check("idle_ro_en_low", int'(ro_en), 0);
        end
        // nominal: period 8 over 64 cycles, done 68 after first busy cycle
        mode = 2;
        run(64, 8, 0, 1'b1, 0, 0);
        mode = 0;
        run(50, 0, 0, 1'b1, 0, 0);
        mode = 1;
        run(50, 0, 0, 1'b1, 0, 0);
        mode = 2;
        run(0, 0, 0, 1'b1, 0, 0);
        mode = 3;
        run(100, CMAX, 1, 1'b1, 0, 0);
        run(10, 0, 0, 1'b0, 0, 0);
        mode = 2;
        run(30, 0, 0, 1'b0, 10, 0);
        run(40, 0, 0, 1'b0, 0, 15);
        run(8, 1, 0, 1'b1, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
